card_datapath: RTL and testbench
================================

CARD_DATAPATH -- requirements
Module: card_datapath

Interface
REQ-001 The module SHALL have port fast_clock, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 The module SHALL have port resetb, input, 1 bit: reset, synchronous, active-high.
REQ-003 The module SHALL have port slow_clock, input, 1 bit: deal step strobe, asynchronous level, sampled in the fast_clock domain.
REQ-004 The module SHALL have ports load_pcard1, load_pcard2, load_pcard3, input, 1 bit each: load the player card 1/2/3 register on the next deal step.
REQ-005 The module SHALL have ports load_dcard1, load_dcard2, load_dcard3, input, 1 bit each: load the dealer card 1/2/3 register on the next deal step.
REQ-006 The module SHALL have port pscore, output, 4 bits: player hand value, 0-9.
REQ-007 The module SHALL have port dscore, output, 4 bits: dealer hand value, 0-9.
REQ-008 The module SHALL have port pcard3, output, 4 bits: raw player card 3 code, 0 = empty, 1-13 = A..K.

Function
REQ-009 The module SHALL contain a 4-bit deal counter that advances by 1 every fast_clock cycle, sequence 1,2,...,13,1 (13 wraps to 1), and never holds 0 or 14-15.
REQ-010 The module SHALL pass slow_clock through three flops (s1, s2, s3) and SHALL define deal_step = s2 AND NOT s3.
REQ-011 On a cycle with deal_step high, each card register whose load_* input is high SHALL capture the current deal counter value; registers whose load_* input is low SHALL hold.
REQ-012 When several load_* inputs are high on the same deal_step, every selected register SHALL capture the same counter value.
REQ-013 load_* inputs SHALL be ignored on cycles without deal_step; a slow_clock high level lasting many cycles SHALL produce exactly one deal_step.
REQ-014 Card point value SHALL be: code 1-9 maps to 1-9; codes 0 and 10-13 map to 0.
REQ-015 pscore SHALL be (sum of the point values of player cards 1-3) mod 10, and dscore the same for dealer cards 1-3, computed in 5-bit arithmetic (max 27) before the modulo.
REQ-016 pscore and dscore SHALL be registered, and SHALL reflect a card register update exactly one fast_clock cycle after the update.
REQ-017 pcard3 SHALL be driven directly from the player card 3 register, with no added latency.
REQ-018 Latency SHALL be as follows: slow_clock rising before fast_clock edge k loads cards at edge k+2, and scores update at edge k+3.

Reset
REQ-019 While resetb is high at a fast_clock edge, all six card registers, pscore, dscore, and s1-s3 SHALL become 0, and the deal counter SHALL become 1.
REQ-020 Reset SHALL override a coincident deal_step, so that no card loads on that cycle.
REQ-021 Reset asserted mid-hand SHALL clear all cards, and after release the scores SHALL read 0 until the next deal_step.
REQ-022 After release the counter SHALL read 2 at the first fast_clock edge with resetb low.

Configuration
REQ-023 When macro CARD_HEX_EN is defined, the module SHALL add outputs HEX0-HEX5, 7 bits each, active-low seven-segment displays of player cards 1-3 and dealer cards 1-3.
REQ-024 The CARD_HEX_EN glyphs SHALL be: 0 = blank, 1 = A, 2-9 = digit, 10 = 0, 11 = J, 12 = q, 13 = K; the glyph decode SHALL be combinational from the card registers.
REQ-025 When CARD_HEX_EN is not defined, ports HEX0-HEX5 and their decode logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-026 Reset, then load_pcard1 = 1 with slow_clock rising timed so the counter reads 7 at load -> pcard1 = 7, pscore = 7 one cycle later, dscore = 0.
REQ-027 Player cards 9, 8, 13 loaded in three deal steps -> pscore = 7 ((9+8+0) mod 10), pcard3 = 13.
REQ-028 load_dcard1 and load_dcard2 both high on one deal_step with counter = 5 -> both registers = 5, dscore = 0.
REQ-029 slow_clock held high for 50 cycles with load_pcard1 = 1 -> exactly one load; pcard1 is unchanged after the first capture.
REQ-030 resetb pulsed high on the same cycle as deal_step -> all cards 0, no load, pscore = dscore = 0, counter = 1.
REQ-031 Counter observed for 30 cycles after reset -> sequence 1..13,1..13,1..4; 0 and 14-15 never appear.

Source files
------------

// File: rtl/card_datapath_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : card_datapath_if                                             |
// | Purpose  : Deal-strobe, card-load and score bus of card_datapath.       |
// | Revision : 1.0                                                          |
// +-------------------------------------------------------------------------+
interface card_datapath_if;
   logic       slow_clock;
   logic       load_pcard1;
   logic       load_pcard2;
   logic       load_pcard3;
   logic       load_dcard1;
   logic       load_dcard2;
   logic       load_dcard3;
   logic [3:0] pscore;
   logic [3:0] dscore;
   logic [3:0] pcard3;

   modport master (
      output slow_clock,
      output load_pcard1, load_pcard2, load_pcard3,
      output load_dcard1, load_dcard2, load_dcard3,
      input  pscore, dscore, pcard3
   );

   modport slave (
      input  slow_clock,
      input  load_pcard1, load_pcard2, load_pcard3,
      input  load_dcard1, load_dcard2, load_dcard3,
      output pscore, dscore, pcard3
   );
endinterface
`default_nettype wire

// File: rtl/card_datapath.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : card_datapath                                                |
// | Purpose  : Card registers, 1..13 deal counter and baccarat hand scores. |
// |            Optional macro CARD_HEX_EN adds seven-segment card outputs.  |
// | Revision : 1.0                                                          |
// +-------------------------------------------------------------------------+
module card_datapath (
   input  logic              fast_clock,
   input  logic              resetb,
`ifdef CARD_HEX_EN
   output logic [6:0]        HEX0,
   output logic [6:0]        HEX1,
   output logic [6:0]        HEX2,
   output logic [6:0]        HEX3,
   output logic [6:0]        HEX4,
   output logic [6:0]        HEX5,
`endif
   card_datapath_if.slave    bus
);

   localparam logic [3:0] CNT_FIRST = 4'd1;
   localparam logic [3:0] CNT_LAST  = 4'd13;

   logic [3:0] cnt_q, cnt_d;
   logic       s1_q, s2_q, s3_q;
   logic       deal_step;

   logic [3:0] pcard1_q, pcard1_d;
   logic [3:0] pcard2_q, pcard2_d;
   logic [3:0] pcard3_q, pcard3_d;
   logic [3:0] dcard1_q, dcard1_d;
   logic [3:0] dcard2_q, dcard2_d;
   logic [3:0] dcard3_q, dcard3_d;

   logic [3:0] pscore_q, pscore_d;
   logic [3:0] dscore_q, dscore_d;

   function automatic logic [3:0] card_points(input logic [3:0] code);
      return (code >= 4'd1 && code <= 4'd9) ? code : 4'd0;
   endfunction

   // Sum never exceeds 27, so two conditional subtractions give mod 10.
   function automatic logic [3:0] hand_score(input logic [3:0] c1,
                                             input logic [3:0] c2,
                                             input logic [3:0] c3);
      logic [4:0] sum;
      sum = {1'b0, card_points(c1)} + {1'b0, card_points(c2)}
          + {1'b0, card_points(c3)};
      if (sum >= 5'd20)
         sum = sum - 5'd20;
      else if (sum >= 5'd10)
         sum = sum - 5'd10;
      return 4'(sum);
   endfunction

   assign deal_step = s2_q & ~s3_q;

   always_comb begin
      cnt_d    = (cnt_q == CNT_LAST) ? CNT_FIRST : cnt_q + 4'd1;
      pcard1_d = pcard1_q;
      pcard2_d = pcard2_q;
      pcard3_d = pcard3_q;
      dcard1_d = dcard1_q;
      dcard2_d = dcard2_q;
      dcard3_d = dcard3_q;
      if (deal_step) begin
         if (bus.load_pcard1) pcard1_d = cnt_q;
         if (bus.load_pcard2) pcard2_d = cnt_q;
         if (bus.load_pcard3) pcard3_d = cnt_q;
         if (bus.load_dcard1) dcard1_d = cnt_q;
         if (bus.load_dcard2) dcard2_d = cnt_q;
         if (bus.load_dcard3) dcard3_d = cnt_q;
      end
      // Scores are taken from the current card registers, hence one cycle behind them.
      pscore_d = hand_score(pcard1_q, pcard2_q, pcard3_q);
      dscore_d = hand_score(dcard1_q, dcard2_q, dcard3_q);
   end

   always_ff @(posedge fast_clock) begin
      if (resetb) begin
         cnt_q    <= CNT_FIRST;
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         s3_q     <= 1'b0;
         pcard1_q <= 4'd0;
         pcard2_q <= 4'd0;
         pcard3_q <= 4'd0;
         dcard1_q <= 4'd0;
         dcard2_q <= 4'd0;
         dcard3_q <= 4'd0;
         pscore_q <= 4'd0;
         dscore_q <= 4'd0;
      end else begin
         cnt_q    <= cnt_d;
         s1_q     <= bus.slow_clock;
         s2_q     <= s1_q;
         s3_q     <= s2_q;
         pcard1_q <= pcard1_d;
         pcard2_q <= pcard2_d;
         pcard3_q <= pcard3_d;
         dcard1_q <= dcard1_d;
         dcard2_q <= dcard2_d;
         dcard3_q <= dcard3_d;
         pscore_q <= pscore_d;
         dscore_q <= dscore_d;
      end
   end

   assign bus.pscore = pscore_q;
   assign bus.dscore = dscore_q;
   assign bus.pcard3 = pcard3_q;

`ifdef CARD_HEX_EN
   // Active-low segments, bit 0 = a ... bit 6 = g.
   function automatic logic [6:0] card_glyph(input logic [3:0] code);
      logic [6:0] seg;
      case (code)
         4'd1:    seg = 7'b0001000;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         4'd10:   seg = 7'b1000000;
         4'd11:   seg = 7'b1100001;
         4'd12:   seg = 7'b0011000;
         4'd13:   seg = 7'b0001001;
         default: seg = 7'b1111111;
      endcase
      return seg;
   endfunction

   always_comb begin
      HEX0 = card_glyph(pcard1_q);
      HEX1 = card_glyph(pcard2_q);
      HEX2 = card_glyph(pcard3_q);
      HEX3 = card_glyph(dcard1_q);
      HEX4 = card_glyph(dcard2_q);
      HEX5 = card_glyph(dcard3_q);
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_card_datapath.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : tb_card_datapath                                             |
// | Purpose  : Directed self-checking bench for card_datapath.              |
// | Revision : 1.0                                                          |
// +-------------------------------------------------------------------------+
module tb_card_datapath;

   logic fast_clock;
   logic resetb;
   card_datapath_if bus ();

`ifdef CARD_HEX_EN
   logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
`endif

   card_datapath dut (
      .fast_clock (fast_clock),
      .resetb     (resetb),
`ifdef CARD_HEX_EN
      .HEX0       (hex0),
      .HEX1       (hex1),
      .HEX2       (hex2),
      .HEX3       (hex3),
      .HEX4       (hex4),
      .HEX5       (hex5),
`endif
      .bus        (bus.slave)
   );

   initial begin
      fast_clock = 1'b0;
      forever #5 fast_clock = ~fast_clock;
   end

   int n_cmp = 0;
   int n_bad = 0;

   // ---------------- reference model ----------------
   // Counter after an edge is 1 + (edges since the reset edge) mod 13.
   // A deal happens at an edge when the sampled strobe was high two edges
   // earlier and low three edges earlier (zeros are assumed at reset).
   bit   model_valid = 1'b0;
   int   edges_since_rst;
   bit   strobe_hist[$];
   int   mp[3];
   int   md[3];
   int   exp_ps, exp_ds;

   function automatic int pts(input int c);
      return (c >= 1 && c <= 9) ? c : 0;
   endfunction

   function automatic int hand(input int a, input int b, input int c);
      return (pts(a) + pts(b) + pts(c)) % 10;
   endfunction

   always @(posedge fast_clock) begin
      if (resetb) begin
         model_valid     = 1'b1;
         edges_since_rst = 0;
         strobe_hist     = '{0, 0, 0};
         for (int i = 0; i < 3; i++) begin
            mp[i] = 0;
            md[i] = 0;
         end
         exp_ps = 0;
         exp_ds = 0;
      end else if (model_valid) begin
         int now_cnt;
         now_cnt = 1 + (edges_since_rst % 13);
         exp_ps  = hand(mp[0], mp[1], mp[2]);
         exp_ds  = hand(md[0], md[1], md[2]);
         if (strobe_hist[1] && !strobe_hist[2]) begin
            if (bus.load_pcard1) mp[0] = now_cnt;
            if (bus.load_pcard2) mp[1] = now_cnt;
            if (bus.load_pcard3) mp[2] = now_cnt;
            if (bus.load_dcard1) md[0] = now_cnt;
            if (bus.load_dcard2) md[1] = now_cnt;
            if (bus.load_dcard3) md[2] = now_cnt;
         end
         strobe_hist.push_front(bus.slow_clock);
         void'(strobe_hist.pop_back());
         edges_since_rst++;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge fast_clock) begin
      if (model_valid) begin
         check("pscore", int'(bus.pscore), exp_ps);
         check("dscore", int'(bus.dscore), exp_ds);
         check("pcard3", int'(bus.pcard3), mp[2]);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge fast_clock);
      #1;
   endtask

   task automatic set_loads(input bit [5:0] l);
      {bus.load_pcard1, bus.load_pcard2, bus.load_pcard3,
       bus.load_dcard1, bus.load_dcard2, bus.load_dcard3} = l;
   endtask

   task automatic do_reset();
      resetb = 1'b1;
      step();
      resetb = 1'b0;
   endtask

   // Raise the strobe so the given counter value is captured, then let scores settle.
   task automatic deal_at(input int target, input bit [5:0] l);
      for (int i = 0; i < 13 && (1 + ((edges_since_rst + 2) % 13)) != target; i++)
         step();
      bus.slow_clock = 1'b1;
      set_loads(l);
      repeat (3) step();
      bus.slow_clock = 1'b0;
      set_loads(6'b0);
      step();
   endtask

   localparam bit [5:0] P1 = 6'b100000, P2 = 6'b010000, P3 = 6'b001000;
   localparam bit [5:0] D1 = 6'b000100, D2 = 6'b000010, D3 = 6'b000001;

   initial begin
      resetb         = 1'b1;
      bus.slow_clock = 1'b0;
      set_loads(6'b0);
      step();
      check("rst_pscore", int'(bus.pscore), 0);
      check("rst_pcard3", int'(bus.pcard3), 0);
      resetb = 1'b0;

      // Player card 1 captured at counter 7.
      deal_at(7, P1);
      check("p1_pscore", int'(bus.pscore), 7);
      check("p1_dscore", int'(bus.dscore), 0);

      // 9 + 8 + K -> 7.
      do_reset();
      deal_at(9, P1);
      deal_at(8, P2);
      deal_at(13, P3);
      check("hand_pscore", int'(bus.pscore), 7);
      check("hand_pcard3", int'(bus.pcard3), 13);

      // Two dealer cards in one step share the counter value.
      deal_at(5, D1 | D2);
      check("dual_dscore", int'(bus.dscore), 0);
      deal_at(3, D3);
      check("dual_dscore3", int'(bus.dscore), 3);
      check("dual_pscore", int'(bus.pscore), 7);

      // Long strobe: exactly one capture.
      do_reset();
      for (int i = 0; i < 13 && (1 + ((edges_since_rst + 2) % 13)) != 4; i++)
         step();
      bus.slow_clock = 1'b1;
      set_loads(P1 | P3);
      repeat (50) step();
      check("hold_pcard3", int'(bus.pcard3), 4);
      check("hold_pscore", int'(bus.pscore), 8);
      bus.slow_clock = 1'b0;
      set_loads(6'b0);
      step();

      // Reset coincident with deal_step.
      bus.slow_clock = 1'b1;
      set_loads(6'b111111);
      step();
      step();
      resetb         = 1'b1;
      bus.slow_clock = 1'b0;
      set_loads(6'b0);
      step();
      resetb = 1'b0;
      check("rstdeal_pcard3", int'(bus.pcard3), 0);
      check("rstdeal_pscore", int'(bus.pscore), 0);
      check("rstdeal_dscore", int'(bus.dscore), 0);
      // Counter restarted at 1, so a deal raised now captures 3.
      bus.slow_clock = 1'b1;
      set_loads(P3);
      repeat (3) step();
      bus.slow_clock = 1'b0;
      set_loads(6'b0);
      check("rstdeal_cnt", int'(bus.pcard3), 3);
      step();
      check("rstdeal_score", int'(bus.pscore), 3);

      // Alternating strobe deals every other count, covering all 13 values.
      do_reset();
      set_loads(P3);
      for (int i = 0; i < 30; i++) begin
         bus.slow_clock = (i % 2 == 0);
         step();
      end
      check("seq_pcard3_a", int'(bus.pcard3), 3);
      bus.slow_clock = 1'b0;
      step();
      check("seq_pcard3_b", int'(bus.pcard3), 5);
      set_loads(6'b0);
      repeat (3) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
